// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for blocks that drive the team's 4-bit ALU.
//   Widths    : ALU_OP_W, ALU_DATA_W, ALU_RES_W
//   Opcodes   : ALU_OP_* constants; codes >= NUM_OPS_DEF are illegal
//   Types     : state_t sequencer states
//   Functions : op_legal() opcode range check
package alu_pkg;

   localparam int unsigned ALU_OP_W   = 4;
   localparam int unsigned ALU_DATA_W = 4;
   localparam int unsigned ALU_RES_W  = 8;

   localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'h0;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 4'h1;
   localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 4'h2;
   localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 4'h3;
   localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 4'h4;
   localparam logic [ALU_OP_W-1:0] ALU_OP_NOT = 4'h5;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SHL = 4'h6;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SHR = 4'h7;
   localparam logic [ALU_OP_W-1:0] ALU_OP_MUL = 4'h8;
   localparam logic [ALU_OP_W-1:0] ALU_OP_CMP = 4'h9;

   localparam int unsigned NUM_OPS_DEF = 10;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   function automatic logic op_legal(input logic [ALU_OP_W-1:0] op,
                                     input int unsigned num_ops);
      return ({28'd0, op} < num_ops);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index; search runs upward from here with wrap
//   grant : one-hot grant (all zero when no request)
//   idx   : index of the granted requester
//   found : at least one request present
module rr_arbiter #(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          found
);

   // Outer loop walks priority order, inner loop keeps every bit select constant.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (((32'(ptr) + k) % N) == i)) begin
               found    = 1'b1;
               grant[i] = 1'b1;
               idx      = IW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq: shares one combinational 4-bit ALU between NREQ requesters.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/ready          : per-requester command handshake
//   req_a/req_b/req_op       : packed commands, requester i at [4i+3:4i]
//   rsp_valid/ready          : per-requester response handshake
//   rsp_data, rsp_err        : shared result and illegal-opcode flag
//   alu_a/alu_b/alu_op       : to ALU;  alu_result : from ALU
//   busy, grant_id           : status
module alu_arbiter_seq
   import alu_pkg::*;
#(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned NUM_OPS = NUM_OPS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [4*NREQ-1:0]     req_a,
   input  logic [4*NREQ-1:0]     req_b,
   input  logic [4*NREQ-1:0]     req_op,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [ALU_RES_W-1:0]  rsp_data,
   output logic                  rsp_err,
   output logic [ALU_DATA_W-1:0] alu_a,
   output logic [ALU_DATA_W-1:0] alu_b,
   output logic [ALU_OP_W-1:0]   alu_op,
   input  logic [ALU_RES_W-1:0]  alu_result,
   output logic                  busy,
   output logic [1:0]            grant_id
);

   state_t                state, state_nx;
   logic [1:0]            rr_ptr;
   logic [2:0]            cnt;
   logic [NREQ-1:0]       arb_grant;
   logic [1:0]            arb_idx;
   logic                  arb_found;
   logic [ALU_DATA_W-1:0] sel_a, sel_b;
   logic [ALU_OP_W-1:0]   sel_op;
   logic                  sel_legal;

   rr_arbiter #(.N(NREQ), .IW(2)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .found (arb_found)
   );

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         sel_a  = sel_a  | (req_a[4*i +: 4]  & {4{arb_grant[i]}});
         sel_b  = sel_b  | (req_b[4*i +: 4]  & {4{arb_grant[i]}});
         sel_op = sel_op | (req_op[4*i +: 4] & {4{arb_grant[i]}});
      end
      sel_legal = op_legal(sel_op, NUM_OPS);
   end

   always_comb begin
      state_nx  = state;
      req_ready = '0;
      rsp_valid = '0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            req_ready = arb_grant;
            if (arb_found) state_nx = sel_legal ? WAIT : RESP;
         end
         WAIT: begin
            if (cnt == 3'(ALU_LAT - 1)) state_nx = RESP;
         end
         RESP: begin
            for (int unsigned i = 0; i < NREQ; i++) begin
               if (grant_id == 2'(i)) begin
                  rsp_valid[i] = 1'b1;
                  if (rsp_ready[i]) state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // The ALU drive registers double as the operand latch: they are loaded only
   // for legal ops, so they already hold steady outside WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         cnt      <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
         grant_id <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (arb_found) begin
                  grant_id <= arb_idx;
                  rr_ptr   <= (arb_idx == 2'(NREQ - 1)) ? 2'd0 : arb_idx + 2'd1;
                  cnt      <= '0;
                  if (sel_legal) begin
                     alu_a  <= sel_a;
                     alu_b  <= sel_b;
                     alu_op <= sel_op;
                  end else begin
                     rsp_data <= '0;
                     rsp_err  <= 1'b1;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt + 3'd1;
               if (cnt == 3'(ALU_LAT - 1)) begin
                  rsp_data <= alu_result;
                  rsp_err  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// tb_alu_arbiter_seq: scoreboard bench for alu_arbiter_seq with a
// behavioural ALU and a transaction-level arbitration/latency model.
module tb_alu_arbiter_seq;
   import alu_pkg::*;

   localparam int NREQ = 2;
   localparam int LAT  = 1;

   typedef struct {
      int          id;
      logic [7:0]  data;
      logic        err;
      int unsigned due;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [4*NREQ-1:0] req_a, req_b, req_op;
   logic [7:0]        rsp_data, alu_result;
   logic              rsp_err, busy;
   logic [3:0]        alu_a, alu_b, alu_op;
   logic [1:0]        grant_id;

   logic [1:0] req_valid3, req_ready3, rsp_valid3, rsp_ready3;
   logic [7:0] req_a3, req_b3, req_op3, rsp_data3, alu_result3;
   logic       rsp_err3, busy3;
   logic [3:0] alu_a3, alu_b3, alu_op3;
   logic [1:0] grant_id3;

   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   exp_t        q[$];
   int          m_ptr = 0;
   logic [1:0]  m_gid = '0;
   logic [3:0]  m_a = '0, m_b = '0, m_op = '0;
   logic [NREQ-1:0] hs_pend = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] op);
      case (op)
         ALU_OP_ADD: return 8'(a) + 8'(b);
         ALU_OP_SUB: return 8'(a) - 8'(b);
         ALU_OP_AND: return {4'h0, a & b};
         ALU_OP_OR:  return {4'h0, a | b};
         ALU_OP_XOR: return {4'h0, a ^ b};
         ALU_OP_NOT: return {4'h0, ~a};
         ALU_OP_SHL: return 8'(a) << b[1:0];
         ALU_OP_SHR: return {4'h0, a >> b[1:0]};
         ALU_OP_MUL: return 8'(a) * 8'(b);
         ALU_OP_CMP: return {7'd0, a < b};
         default:    return 8'h00;
      endcase
   endfunction

   assign alu_result  = alu_ref(alu_a, alu_b, alu_op);
   assign alu_result3 = alu_ref(alu_a3, alu_b3, alu_op3);

   alu_arbiter_seq #(.NREQ(NREQ), .ALU_LAT(LAT), .NUM_OPS(10)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .busy(busy), .grant_id(grant_id)
   );

   alu_arbiter_seq #(.NREQ(2), .ALU_LAT(3), .NUM_OPS(10)) u_dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_a(req_a3), .req_b(req_b3), .req_op(req_op3), .rsp_valid(rsp_valid3),
      .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_err(rsp_err3),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_result(alu_result3),
      .busy(busy3), .grant_id(grant_id3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic send(input int i, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op);
      req_valid[i]      = 1'b1;
      req_a[4*i +: 4]   = a;
      req_b[4*i +: 4]   = b;
      req_op[4*i +: 4]  = op;
   endtask

   task automatic begin_cycle();
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         if (hs_pend[i]) begin
            req_valid[i] = 1'b0;
            hs_pend[i]   = 1'b0;
         end
      end
   endtask

   task automatic end_cycle();
      logic [NREQ-1:0] exp_rdy;
      int              w;
      exp_t            e;
      logic [3:0]      ca, cb, cop;
      #1;
      if (rst) return;
      exp_rdy = '0;
      w = -1;
      if (q.size() == 0) begin
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         if (w >= 0) exp_rdy[w] = 1'b1;
      end
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_op", 32'(alu_op), 32'(m_op));
      if (w >= 0) begin
         ca  = req_a[4*w +: 4];
         cb  = req_b[4*w +: 4];
         cop = req_op[4*w +: 4];
         e.id = w;
         hs_pend[w] = 1'b1;
         m_gid = 2'(w);
         m_ptr = (w + 1) % NREQ;
         if (int'(cop) < 10) begin
            e.data = alu_ref(ca, cb, cop);
            e.err  = 1'b0;
            e.due  = cyc + LAT + 1;
            m_a = ca; m_b = cb; m_op = cop;
         end else begin
            e.data = 8'h00;
            e.err  = 1'b1;
            e.due  = cyc + 1;
         end
         q.push_back(e);
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 60; n++) begin
         begin_cycle();
         rsp_ready = '1;
         end_cycle();
         if (q.size() == 0 && req_valid == '0 && hs_pend == '0) break;
      end
      chk("drain_timeout", 32'(q.size() != 0 || req_valid != '0), 32'd0);
   endtask

   // Response monitor: pops the scoreboard whenever a response is accepted.
   initial begin
      logic [NREQ-1:0] exp_v;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (q.size() != 0 && cyc >= q[0].due) begin
               exp_v = '0;
               exp_v[q[0].id] = 1'b1;
               chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
               chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
               chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
               if (rsp_ready[q[0].id]) void'(q.pop_front());
            end else begin
               chk("rsp_valid_quiet", 32'(rsp_valid), 32'd0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
      req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_op3 = '0; rsp_ready3 = 2'b11;
      repeat (3) begin begin_cycle(); end_cycle(); end
      begin_cycle(); rst = 1'b0; end_cycle();
      chk("reset_rsp_data", 32'(rsp_data), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);

      // Single ADD 7+5 from requester 0.
      begin_cycle(); rsp_ready = '1; send(0, 4'h7, 4'h5, ALU_OP_ADD); end_cycle();
      drain();

      // Contention: both requesters keep a command pending.
      for (int n = 0; n < 16; n++) begin
         begin_cycle();
         rsp_ready = '1;
         if (!req_valid[0]) send(0, 4'h3, 4'h1, ALU_OP_SUB);
         if (!req_valid[1]) send(1, 4'h2, 4'h2, ALU_OP_ADD);
         end_cycle();
      end
      drain();

      // Backpressure on requester 1 while requester 0 waits.
      begin_cycle(); rsp_ready = 2'b01; send(1, 4'h9, 4'h3, ALU_OP_MUL); end_cycle();
      begin_cycle(); send(0, 4'h4, 4'h4, ALU_OP_ADD); end_cycle();
      repeat (LAT + 5) begin begin_cycle(); end_cycle(); end
      drain();

      // Illegal opcode.
      begin_cycle(); send(0, 4'h3, 4'h3, 4'hF); end_cycle();
      drain();

      // Randomized traffic with random response backpressure.
      for (int n = 0; n < 400; n++) begin
         begin_cycle();
         for (int i = 0; i < NREQ; i++)
            if (!req_valid[i] && $urandom_range(0, 3) != 0)
               send(i, 4'($urandom), 4'($urandom), 4'($urandom_range(0, 15)));
         rsp_ready = NREQ'($urandom);
         end_cycle();
      end
      drain();

      // Reset while the op sits in WAIT: it must vanish.
      begin_cycle(); send(0, 4'h1, 4'h2, ALU_OP_ADD); end_cycle();
      begin_cycle();
      rst = 1'b1;
      q.delete();
      m_ptr = 0; m_gid = '0; m_a = '0; m_b = '0; m_op = '0;
      end_cycle();
      begin_cycle(); rst = 1'b0; end_cycle();
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (6) begin begin_cycle(); end_cycle(); end

      // ALU_LAT=3 instance: ADD F+F responds in cycle 4.
      @(negedge clk);
      req_valid3 = 2'b01; req_a3 = 8'h0F; req_b3 = 8'h0F; req_op3 = {4'h0, ALU_OP_ADD};
      #1;
      chk("lat3_ready", 32'(req_ready3), 32'h1);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) req_valid3 = '0;
         #1;
         if (c < 4) begin
            chk("lat3_wait_valid", 32'(rsp_valid3), 32'd0);
            chk("lat3_alu_a", 32'(alu_a3), 32'hF);
         end else begin
            chk("lat3_rsp_valid", 32'(rsp_valid3), 32'h1);
            chk("lat3_rsp_data", 32'(rsp_data3), 32'h1E);
            chk("lat3_rsp_err", 32'(rsp_err3), 32'd0);
         end
      end
      @(negedge clk); #1;
      chk("lat3_idle", 32'(busy3), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_arbiter_seq.md
Name: alu_arbiter_seq

Overview:
- Shares the team's single 4-bit ALU (4-bit A/B operands, 4-bit opcode, 8-bit result) between NREQ requesters.
- Per-requester valid/ready command and response channels; round-robin arbitration.
- Latches the granted operands and opcode, drives the ALU for ALU_LAT cycles, captures the result and returns it to the granted requester.
- Sits between requester logic (e.g. host-interface and self-test sequencers) and the ALU instance inside the top-level user project.

Parameters:
- NREQ, 2, number of requesters (2..4).
- ALU_LAT, 1, cycles from ALU input drive to result capture (1..7).
- NUM_OPS, 10, opcodes >= NUM_OPS are illegal and are not issued to the ALU.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  command valid per requester.
- req_ready  out  NREQ  command accepted (at most one bit high).
- req_a  in  4*NREQ  operand A, requester i at [4i+3:4i].
- req_b  in  4*NREQ  operand B, same packing.
- req_op  in  4*NREQ  opcode, same packing.
- rsp_valid  out  NREQ  response valid (at most one bit high).
- rsp_ready  in  NREQ  response accepted per requester.
- rsp_data  out  8  result, shared by all requesters; qualify with rsp_valid.
- rsp_err  out  1  illegal opcode flag; qualify with rsp_valid.
- alu_a  out  4  to ALU operand A.
- alu_b  out  4  to ALU operand B.
- alu_op  out  4  to ALU opcode.
- alu_result  in  8  from ALU (combinational ALU).
- busy  out  1  high whenever state != IDLE.
- grant_id  out  2  index of current/last granted requester.

Behaviour:
- Reset: state IDLE; req_ready=0; rsp_valid=0; rsp_data=0; rsp_err=0; alu_a/b/op=0; busy=0; grant_id=0; rr pointer=0; wait counter=0.
- Reset mid-operation aborts the in-flight op. No response is produced and the requester must reissue.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap to 0.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready=0.
  - No valid requests: stay IDLE, all req_ready=0.
  - On handshake, register A, B, op and grant_id=winner; rr_ptr <= winner+1 mod NREQ.
  - Legal op: go to WAIT, counter=0.
  - Illegal op (op >= NUM_OPS): go directly to RESP with rsp_err=1, rsp_data=0. The ALU outputs are not updated.
- WAIT:
  - alu_a/b/op driven from the latched registers; they hold their values outside WAIT.
  - Counter increments each cycle.
  - In the cycle where counter==ALU_LAT-1, register rsp_data<=alu_result and rsp_err<=0, then go to RESP.
- RESP:
  - rsp_valid[grant_id]=1; rsp_data and rsp_err stable.
  - Stays until rsp_ready[grant_id]=1, then next state is IDLE.
  - rsp_ready of non-granted requesters is ignored.
- Timing: command handshake in cycle 0 → WAIT in cycles 1..ALU_LAT → rsp_valid from cycle ALU_LAT+1.
  - Peak throughput is one op per ALU_LAT+2 cycles; for illegal ops the RESP cycle is 1.
- No acceptance during WAIT/RESP: req_ready=0 there, and requesters hold valid (AXI-style; valid may not drop before ready).
- Simultaneous requests: exactly one is granted per IDLE cycle. The others wait, and round-robin rotation prevents starvation.
- A requester whose response is in RESP may present its next command; it is arbitrated only after returning to IDLE.
- NREQ=1 degenerates to a pass-through sequencer, with rr_ptr constant 0.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_OP_W=4, ALU_DATA_W=4, ALU_RES_W=8.
  - Opcode constants (ALU_OP_ADD=4'h0, ALU_OP_SUB=4'h1, ...), NUM_OPS default, state enum {IDLE,WAIT,RESP}.
- One sub-module: rr_arbiter (NREQ-wide request vector + pointer → one-hot grant + index), reused later by other shared-resource blocks.

Test Plan:
- Single op, ALU_LAT=1:
  - Stimulus: requester 0 sends A=4'h7, B=4'h5, op=ADD.
  - Response: req_ready[0] in cycle 0; alu_a=7, alu_b=5, alu_op=0 in cycle 1; rsp_valid[0]=1, rsp_data=8'h0C, rsp_err=0 in cycle 2.
- Contention:
  - Stimulus: both requesters valid continuously from reset, r0 A=3 B=1 SUB, r1 A=2 B=2 ADD, rsp_ready tied 1.
  - Response: grants alternate 0,1,0,1; responses 8'h02 then 8'h04; never two consecutive grants to the same requester.
- Response backpressure:
  - Stimulus: rsp_ready[1]=0 for 5 cycles.
  - Response: rsp_valid[1] and rsp_data held stable for 5 cycles; req_ready all 0 and busy=1 throughout; IDLE one cycle after rsp_ready[1]=1.
- Illegal opcode:
  - Stimulus: op=4'hF.
  - Response: rsp_valid in cycle 1 with rsp_err=1, rsp_data=0; alu_op unchanged from its previous value.
- Latency parameter:
  - Stimulus: ALU_LAT=3, ADD 4'hF+4'hF.
  - Response: rsp_valid in cycle 4, rsp_data=8'h1E.
- Reset mid-op:
  - Stimulus: rst asserted in WAIT.
  - Response: next cycle rsp_valid=0, busy=0, alu_*=0, grant_id=0; no response ever appears for the aborted op.
